// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with datapath enables
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multicycle_control #(
  parameter int MCODEBITS = 3,
  parameter int OPWIDTH   = 3,
  parameter int CNTW      = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 Halt,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 MemReady,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 Done,
  output logic [CNTW-1:0]      CycleCount,
  output logic [CNTW-1:0]      InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [2:0] c_OP_LW     = 3'b000;
  localparam logic [2:0] c_OP_SW     = 3'b001;
  localparam logic [2:0] c_OP_SET    = 3'b101;
  localparam logic [2:0] c_OP_BRANCH = 3'b111;
  localparam logic [OPWIDTH-1:0] c_ALU_DEFAULT = OPWIDTH'(3'b010);
  localparam logic [OPWIDTH-1:0] c_ALU_BRANCH  = OPWIDTH'(3'b111);

  state_t                 r_state;
  state_t                 w_next;
  logic [MCODEBITS-1:0]   r_op;
  logic [CNTW-1:0]        r_cyc_cnt;
  logic [CNTW-1:0]        r_ins_cnt;
  logic [2:0]             w_op3;
  logic                   w_nop;
  logic [OPWIDTH-1:0]     w_alu_op;
  logic                   w_is_lw;
  logic                   w_is_sw;
  logic                   w_is_set;

  // Opcodes beyond the 3-bit map only exist when the field is wider than 3 bits
  generate
    if (MCODEBITS > 3) begin : g_nop_wide
      assign w_nop = |r_op[MCODEBITS-1:3];
    end else begin : g_nop_narrow
      assign w_nop = 1'b0;
    end
  endgenerate

  assign w_op3    = 3'(r_op);
  assign w_alu_op = OPWIDTH'(w_op3);
  assign w_is_lw  = !w_nop && (w_op3 == c_OP_LW);
  assign w_is_sw  = !w_nop && (w_op3 == c_OP_SW);
  assign w_is_set = !w_nop && (w_op3 == c_OP_SET);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && !Halt) begin
        r_op <= instr;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    Done     = 1'b0;
    ALUOp    = c_ALU_DEFAULT;
    case (r_state)
      S_IDLE: begin
        if (Start) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (Halt) begin
          w_next = S_DONE;
        end else begin
          IRWrite = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_nop) begin
          PCWrite = 1'b1;
          w_next  = S_FETCH;
        end else begin
          ALUOp = w_alu_op;
          case (w_op3)
            c_OP_LW, c_OP_SW: w_next = S_MEM;
            c_OP_SET: begin
              ALUSrc = 1'b1;
              w_next = S_WB;
            end
            c_OP_BRANCH: begin
              Branch  = 1'b1;
              PCWrite = 1'b1;
              ALUOp   = c_ALU_BRANCH;
              w_next  = S_FETCH;
            end
            default: w_next = S_WB;
          endcase
        end
      end
      S_MEM: begin
        // Request stays asserted until the memory acknowledges
        MemRead  = w_is_lw;
        MemWrite = w_is_sw;
        if (MemReady) begin
          if (w_is_lw) begin
            w_next = S_WB;
          end else begin
            PCWrite = 1'b1;
            w_next  = S_FETCH;
          end
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        MemtoReg = w_is_lw;
        ALUOp    = w_alu_op;
        ALUSrc   = w_is_set;
        w_next   = S_FETCH;
      end
      S_DONE: begin
        Done = 1'b1;
        if (Start) w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cyc_cnt <= '0;
      r_ins_cnt <= '0;
    end else begin
      if (r_state != S_IDLE && r_state != S_DONE && r_cyc_cnt != '1) begin
        r_cyc_cnt <= r_cyc_cnt + CNTW'(1);
      end
      if (PCWrite && r_ins_cnt != '1) begin
        r_ins_cnt <= r_ins_cnt + CNTW'(1);
      end
    end
  end

  assign CycleCount = r_cyc_cnt;
  assign InstrCount = r_ins_cnt;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control: vector table with scoreboard plus reset/saturation runs
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

  localparam logic [8:0] E_IR  = 9'b100000000;
  localparam logic [8:0] E_PC  = 9'b010000000;
  localparam logic [8:0] E_BR  = 9'b001000000;
  localparam logic [8:0] E_MR  = 9'b000100000;
  localparam logic [8:0] E_MW  = 9'b000010000;
  localparam logic [8:0] E_MTR = 9'b000001000;
  localparam logic [8:0] E_AS  = 9'b000000100;
  localparam logic [8:0] E_RW  = 9'b000000010;
  localparam logic [8:0] E_DN  = 9'b000000001;

  typedef struct {
    logic       start;
    logic       halt;
    logic [3:0] instr;
    logic       mready;
    logic [8:0] en;
    logic [2:0] alu;
    int         cyc;
    int         ins;
  } vec_t;

  typedef struct {
    int         idx;
    logic [8:0] en;
    logic [2:0] alu;
    int         cyc;
    int         ins;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: 4-bit opcodes, 16-bit counters
  logic        rst_n, start, halt, mready;
  logic [3:0]  instr;
  logic        irw, pcw, br, mrd, mwr, mtr, asrc, rw, dn;
  logic [2:0]  aluop;
  logic [15:0] cyc, ins;

  // saturation instance: 3-bit opcodes, 4-bit counters
  logic        s_rst_n, s_start, s_halt;
  logic [2:0]  s_instr;
  logic        s_irw, s_pcw, s_br, s_mrd, s_mwr, s_mtr, s_asrc, s_rw, s_dn;
  logic [2:0]  s_aluop;
  logic [3:0]  s_cyc, s_ins;

  multicycle_control #(.MCODEBITS(4), .OPWIDTH(3), .CNTW(16)) u_dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Halt(halt), .instr(instr),
    .MemReady(mready), .IRWrite(irw), .PCWrite(pcw), .Branch(br),
    .MemRead(mrd), .MemWrite(mwr), .MemtoReg(mtr), .ALUSrc(asrc),
    .RegWrite(rw), .ALUOp(aluop), .Done(dn), .CycleCount(cyc), .InstrCount(ins)
  );

  multicycle_control #(.MCODEBITS(3), .OPWIDTH(3), .CNTW(4)) u_sat (
    .Clk(clk), .Reset_n(s_rst_n), .Start(s_start), .Halt(s_halt), .instr(s_instr),
    .MemReady(1'b1), .IRWrite(s_irw), .PCWrite(s_pcw), .Branch(s_br),
    .MemRead(s_mrd), .MemWrite(s_mwr), .MemtoReg(s_mtr), .ALUSrc(s_asrc),
    .RegWrite(s_rw), .ALUOp(s_aluop), .Done(s_dn), .CycleCount(s_cyc), .InstrCount(s_ins)
  );

  wire [8:0] w_en = {irw, pcw, br, mrd, mwr, mtr, asrc, rw, dn};

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  exp_t sb[$];
  exp_t m_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input logic st, input logic hl, input logic [3:0] op, input logic mr,
                   input logic [8:0] en, input logic [2:0] alu, input int c, input int n);
    vecs.push_back('{st, hl, op, mr, en, alu, c, n});
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      m_e = sb.pop_front();
      chk($sformatf("vec%0d_enables", m_e.idx), 32'(w_en), 32'(m_e.en));
      chk($sformatf("vec%0d_aluop", m_e.idx), 32'(aluop), 32'(m_e.alu));
      chk($sformatf("vec%0d_cycles", m_e.idx), 32'(cyc), 32'(m_e.cyc));
      chk($sformatf("vec%0d_instrs", m_e.idx), 32'(ins), 32'(m_e.ins));
    end
  end

  initial begin
    // start halt op mr  enables            alu     cyc ins
    v(1, 0, 0, 1, 9'd0,               3'b010,  0, 0);  // IDLE
    v(0, 0, 3, 1, E_IR,               3'b010,  0, 0);  // ADD fetch
    v(0, 0, 0, 1, 9'd0,               3'b010,  1, 0);
    v(0, 0, 0, 1, 9'd0,               3'b011,  2, 0);
    v(0, 0, 0, 1, E_PC | E_RW,        3'b011,  3, 0);
    v(0, 0, 0, 1, E_IR,               3'b010,  4, 1);  // lw fetch
    v(0, 0, 0, 1, 9'd0,               3'b010,  5, 1);
    v(0, 0, 0, 1, 9'd0,               3'b000,  6, 1);
    v(0, 0, 0, 0, E_MR,               3'b010,  7, 1);
    v(0, 0, 0, 0, E_MR,               3'b010,  8, 1);
    v(0, 0, 0, 0, E_MR,               3'b010,  9, 1);
    v(0, 0, 0, 1, E_MR,               3'b010, 10, 1);
    v(0, 0, 0, 1, E_PC | E_RW | E_MTR, 3'b000, 11, 1);
    v(0, 0, 1, 1, E_IR,               3'b010, 12, 2);  // sw fetch
    v(0, 0, 0, 1, 9'd0,               3'b010, 13, 2);
    v(0, 0, 0, 1, 9'd0,               3'b001, 14, 2);
    v(0, 0, 0, 1, E_MW | E_PC,        3'b010, 15, 2);
    v(0, 0, 7, 1, E_IR,               3'b010, 16, 3);  // BRANCH fetch
    v(0, 0, 0, 1, 9'd0,               3'b010, 17, 3);
    v(0, 0, 0, 1, E_BR | E_PC,        3'b111, 18, 3);
    v(0, 0, 5, 1, E_IR,               3'b010, 19, 4);  // SET fetch
    v(0, 0, 0, 1, 9'd0,               3'b010, 20, 4);
    v(0, 0, 0, 1, E_AS,               3'b101, 21, 4);
    v(0, 0, 0, 1, E_AS | E_RW | E_PC, 3'b101, 22, 4);
    v(0, 0, 8, 1, E_IR,               3'b010, 23, 5);  // NOP fetch
    v(0, 0, 0, 1, 9'd0,               3'b010, 24, 5);
    v(0, 0, 0, 1, E_PC,               3'b010, 25, 5);
    v(0, 1, 0, 1, 9'd0,               3'b010, 26, 6);  // halt in FETCH
    v(0, 0, 0, 1, E_DN,               3'b010, 27, 6);
    v(0, 0, 0, 1, E_DN,               3'b010, 27, 6);
    v(1, 0, 0, 1, E_DN,               3'b010, 27, 6);
    v(0, 0, 6, 1, E_IR,               3'b010, 27, 6);  // XOR fetch
    v(0, 1, 0, 1, 9'd0,               3'b010, 28, 6);  // halt ignored
    v(1, 0, 0, 1, 9'd0,               3'b110, 29, 6);  // start ignored
    v(0, 0, 0, 1, E_PC | E_RW,        3'b110, 30, 6);
    v(0, 1, 0, 1, 9'd0,               3'b010, 31, 7);
    v(0, 0, 0, 1, E_DN,               3'b010, 32, 7);

    rst_n = 1'b0; start = 1'b0; halt = 1'b0; instr = '0; mready = 1'b1;
    s_rst_n = 1'b0; s_start = 1'b0; s_halt = 1'b0; s_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_enables", 32'(w_en), 32'd0);
    chk("reset_aluop", 32'(aluop), 32'd2);
    rst_n = 1'b1;
    s_rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      start  = vecs[i].start;
      halt   = vecs[i].halt;
      instr  = vecs[i].instr;
      mready = vecs[i].mready;
      sb.push_back('{i, vecs[i].en, vecs[i].alu, vecs[i].cyc, vecs[i].ins});
      @(posedge clk);
      #1;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    // reset asserted part-way through EXEC of an ADD
    halt = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; instr = 4'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_exec_aluop", 32'(aluop), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_enables", 32'(w_en), 32'd0);
    chk("midreset_aluop", 32'(aluop), 32'd2);
    chk("midreset_cycles", 32'(cyc), 32'd0);
    chk("midreset_instrs", 32'(ins), 32'd0);
    @(posedge clk); #1;
    chk("held_reset_enables", 32'(w_en), 32'd0);
    rst_n = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_fetch_irwrite", 32'(irw), 32'd1);
    chk("restart_cycles", 32'(cyc), 32'd0);

    // 20 ADDs on the 4-bit counter instance
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; s_instr = 3'd3;
    chk("sat_first_fetch", 32'(s_irw), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("sat_instrs_10", 32'(s_ins), 32'd10);
    chk("sat_cycles_clamped", 32'(s_cyc), 32'd15);
    repeat (40) @(posedge clk);
    #1;
    chk("sat_instrs_clamped", 32'(s_ins), 32'd15);
    s_halt = 1'b1;
    @(posedge clk); #1;
    s_halt = 1'b0;
    chk("sat_done", 32'(s_dn), 32'd1);
    chk("sat_done_instrs", 32'(s_ins), 32'd15);
    chk("sat_done_cycles", 32'(s_cyc), 32'd15);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_done_held", 32'(s_dn), 32'd1);
    chk("sat_done_no_regwrite", 32'(s_rw), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
